// File: rtl/scalar_wb_arbiter.sv
// Scalar register-file write-back arbiter: loads first, then buffered ALU results, then direct ALU.
// Build option WB_ZERO_DROP_EN: results targeting register 0 are discarded at acceptance.
module scalar_wb_arbiter #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_wd,
    output logic                     alu_stall,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_rd,
    input  logic [DW-1:0]            ld_wd,
    output logic [AW-1:0]            RD,
    output logic [DW-1:0]            WD,
    output logic                     WES,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

`ifdef WB_ZERO_DROP_EN
    localparam bit ZERO_DROP = 1'b1;
`else
    localparam bit ZERO_DROP = 1'b0;
`endif

    logic [AW-1:0]    rd_mem_q [DEPTH];
    logic [DW-1:0]    wd_mem_q [DEPTH];
    logic [DEPTH-1:0] sq_q,    sq_d;
    logic [PW-1:0]    head_q,  head_d;
    logic [PW-1:0]    tail_q,  tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             stall_q, stall_d;
    logic [AW-1:0]    rd_q,    rd_d;
    logic [DW-1:0]    wd_q,    wd_d;
    logic             wes_q,   wes_d;

    logic ld_take;
    logic alu_take;
    logic buf_nonempty;
    logic head_sq;
    logic pop;
    logic push;
    logic direct;

    // Source selection, squash marking and buffer bookkeeping
    always_comb begin
        ld_take      = ld_valid && !(ZERO_DROP && (ld_rd == '0));
        alu_take     = alu_valid && !stall_q
                       && !(ZERO_DROP && (alu_rd == '0))
                       && !(ld_take && (alu_rd == ld_rd));
        buf_nonempty = (count_q != '0);
        head_sq      = sq_q[head_q] || (ld_take && (rd_mem_q[head_q] == ld_rd));
        // A squashed head leaves without a write, so it may drain alongside a load
        pop          = buf_nonempty && (head_sq || !ld_take);
        direct       = alu_take && !buf_nonempty && !ld_take;
        push         = alu_take && !direct;

        wes_d = 1'b0;
        rd_d  = rd_q;
        wd_d  = wd_q;
        if (ld_take) begin
            wes_d = 1'b1;
            rd_d  = ld_rd;
            wd_d  = ld_wd;
        end else if (buf_nonempty) begin
            if (!head_sq) begin
                wes_d = 1'b1;
                rd_d  = rd_mem_q[head_q];
                wd_d  = wd_mem_q[head_q];
            end
        end else if (direct) begin
            wes_d = 1'b1;
            rd_d  = alu_rd;
            wd_d  = alu_wd;
        end

        sq_d = sq_q;
        if (ld_take) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (rd_mem_q[i] == ld_rd) begin
                    sq_d[i] = 1'b1;
                end
            end
        end
        if (push) begin
            sq_d[tail_q] = 1'b0;
        end

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        stall_d = (count_d == CW'(DEPTH));
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            rd_q    <= '0;
            wd_q    <= '0;
            wes_q   <= 1'b0;
        end else begin
            sq_q    <= sq_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
            rd_q    <= rd_d;
            wd_q    <= wd_d;
            wes_q   <= wes_d;
        end
    end

    // Payload storage; occupancy is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[tail_q] <= alu_rd;
            wd_mem_q[tail_q] <= alu_wd;
        end
    end

    assign RD        = rd_q;
    assign WD        = wd_q;
    assign WES       = wes_q;
    assign pending   = count_q;
    assign alu_stall = stall_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Self-checking bench for scalar_wb_arbiter: directed scenarios plus a random run against a write scoreboard.
module tb_scalar_wb_arbiter;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

`ifdef WB_ZERO_DROP_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
    } wr_t;

    typedef struct {
        bit lv; int lrd; int lwd;
        bit av; int ard; int awd;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_wd;
    logic          alu_stall;
    logic          ld_valid;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_wd;
    logic [AW-1:0] RD;
    logic [DW-1:0] WD;
    logic          WES;
    logic [2:0]    pending;

    int  n_chk  = 0;
    int  n_pass = 0;
    wr_t alu_q[$];
    bit  ld_pend;
    wr_t ld_exp;
    logic [DW-1:0] shadow [32];

    scalar_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_wd(ld_wd),
        .RD(RD), .WD(WD), .WES(WES), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus and update the expected-write model
    task automatic drive(input bit lv, input int lrd, input int lwd,
                         input bit av, input int ard, input int awd);
        bit le;
        bit aa;
        ld_valid  = lv;
        ld_rd     = AW'(lrd);
        ld_wd     = DW'(lwd);
        alu_valid = av;
        alu_rd    = AW'(ard);
        alu_wd    = DW'(awd);
        le = lv && !(ZD && (AW'(lrd) == '0));
        aa = av && (alu_stall == 1'b0);
        if (le) begin
            for (int i = alu_q.size() - 1; i >= 0; i--) begin
                if (alu_q[i].rd == AW'(lrd)) alu_q.delete(i);
            end
        end
        if (aa && !(ZD && (AW'(ard) == '0)) && !(le && (AW'(ard) == AW'(lrd))))
            alu_q.push_back('{rd: AW'(ard), wd: DW'(awd)});
        ld_pend = le;
        ld_exp  = '{rd: AW'(lrd), wd: DW'(lwd)};
    endtask

    task automatic set_idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (WES !== 1'b0 || RD !== '0 || WD !== '0) $display("FAIL reset_out: wes=%b rd=%0d wd=%h, need 0/0/0", WES, RD, WD);
        else n_pass++;
        n_chk++;
        if (pending !== 3'd0) $display("FAIL reset_pending: got %0d need 0", pending);
        else n_pass++;
        n_chk++;
        if (alu_stall !== 1'b0) $display("FAIL reset_stall: got %b need 0", alu_stall);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (WES !== 1'b0) $display("FAIL reset_release_wes: got %b need 0", WES);
        else n_pass++;
    endtask

    task automatic test_alu_only();
        drive(0, 0, 0, 1, 7, 16'hAABB);
        @(posedge clk);
        #1;
        n_chk++;
        if (WES !== 1'b1 || RD !== 5'd7 || WD !== 16'hAABB)
            $display("FAIL alu_only: wes=%b rd=%0d wd=%h, need 1/7/aabb", WES, RD, WD);
        else n_pass++;
        n_chk++;
        if (pending !== 3'd0) $display("FAIL alu_only_pending: got %0d need 0", pending);
        else n_pass++;
        alu_q.delete();
        set_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_conflict();
        drive(1, 3, 16'h1234, 1, 5, 16'h5678);
        @(posedge clk);
        #1;
        n_chk++;
        if (WES !== 1'b1 || RD !== 5'd3 || WD !== 16'h1234 || pending !== 3'd1)
            $display("FAIL conflict_c1: wes=%b rd=%0d wd=%h pend=%0d, need 1/3/1234/1", WES, RD, WD, pending);
        else n_pass++;
        set_idle();
        @(posedge clk);
        #1;
        n_chk++;
        if (WES !== 1'b1 || RD !== 5'd5 || WD !== 16'h5678 || pending !== 3'd0)
            $display("FAIL conflict_c2: wes=%b rd=%0d wd=%h pend=%0d, need 1/5/5678/0", WES, RD, WD, pending);
        else n_pass++;
        alu_q.delete();
        @(posedge clk);
        #1;
        n_chk++;
        if (WES !== 1'b0 || RD !== 5'd5 || WD !== 16'h5678)
            $display("FAIL idle_hold: wes=%b rd=%0d wd=%h, need 0/5/5678", WES, RD, WD);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        drive(0, 0, 0, 1, 0, 16'hFFFF);
        @(posedge clk);
        #1;
        n_chk++;
`ifdef WB_ZERO_DROP_EN
        if (WES !== 1'b0) $display("FAIL zero_alu: wes=%b rd=%0d, need wes 0", WES, RD);
        else n_pass++;
`else
        if (WES !== 1'b1 || RD !== 5'd0 || WD !== 16'hFFFF)
            $display("FAIL zero_alu: wes=%b rd=%0d wd=%h, need 1/0/ffff", WES, RD, WD);
        else n_pass++;
`endif
        alu_q.delete();
        drive(1, 0, 16'h0F0F, 0, 0, 0);
        @(posedge clk);
        #1;
        n_chk++;
`ifdef WB_ZERO_DROP_EN
        if (WES !== 1'b0) $display("FAIL zero_ld: wes=%b rd=%0d, need wes 0", WES, RD);
        else n_pass++;
`else
        if (WES !== 1'b1 || RD !== 5'd0 || WD !== 16'h0F0F)
            $display("FAIL zero_ld: wes=%b rd=%0d wd=%h, need 1/0/0f0f", WES, RD, WD);
        else n_pass++;
`endif
        set_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_squash();
        stim_t tbl[14];
        wr_t   exp;
        tbl[0]  = '{1, 2,  'h2222, 1, 9,  'h0009};
        tbl[1]  = '{1, 3,  'h3333, 1, 10, 'h0001};
        tbl[2]  = '{1, 10, 'h0002, 0, 0,  0};
        tbl[3]  = '{0, 0,  0,      0, 0,  0};
        tbl[4]  = '{0, 0,  0,      0, 0,  0};
        tbl[5]  = '{1, 4,  'h4444, 1, 11, 'h0011};
        tbl[6]  = '{1, 11, 'h00BB, 1, 12, 'h0012};
        tbl[7]  = '{1, 13, 'h00CC, 0, 0,  0};
        tbl[8]  = '{1, 14, 'h0E0E, 1, 14, 'hDEAD};
        for (int i = 9; i < 14; i++) tbl[i] = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        for (int c = 0; c < 14; c++) begin
            drive(tbl[c].lv, tbl[c].lrd, tbl[c].lwd, tbl[c].av, tbl[c].ard, tbl[c].awd);
            @(posedge clk);
            #1;
            if (WES === 1'b1) shadow[RD] = WD;
            n_chk++;
            if (ld_pend) begin
                if (WES !== 1'b1 || RD !== ld_exp.rd || WD !== ld_exp.wd)
                    $display("FAIL squash_ld c%0d: wes=%b rd=%0d wd=%h, need rd=%0d wd=%h", c, WES, RD, WD, ld_exp.rd, ld_exp.wd);
                else n_pass++;
            end else if (WES === 1'b1) begin
                if (alu_q.size() == 0) $display("FAIL squash_extra c%0d: unexpected write rd=%0d wd=%h", c, RD, WD);
                else begin
                    exp = alu_q.pop_front();
                    if (RD !== exp.rd || WD !== exp.wd)
                        $display("FAIL squash_alu c%0d: rd=%0d wd=%h, need rd=%0d wd=%h", c, RD, WD, exp.rd, exp.wd);
                    else n_pass++;
                end
            end else n_pass++;
            if (c == 6) begin
                n_chk++;
                if (pending !== 3'd1) $display("FAIL squash_head_pop: pending=%0d need 1", pending);
                else n_pass++;
            end
        end
        n_chk++;
        if (shadow[10] !== 16'h0002 || shadow[14] !== 16'h0E0E || shadow[12] !== 16'h0012)
            $display("FAIL squash_final: r10=%h r12=%h r14=%h, need 0002/0012/0e0e", shadow[10], shadow[12], shadow[14]);
        else n_pass++;
        n_chk++;
        if (pending !== 3'd0 || alu_q.size() != 0)
            $display("FAIL squash_drain: pending=%0d model=%0d, need 0/0", pending, alu_q.size());
        else n_pass++;
    endtask

    task automatic test_fill();
        int  k = 0;
        wr_t exp;
        for (int c = 0; c < 30; c++) begin
            drive(c < 6, c + 1, 16'h1000 + c, k < 10, 16 + k, 16'hA000 + k);
            if (k < 10 && alu_stall !== 1'b1) k++;
            @(posedge clk);
            #1;
            n_chk++;
            if (ld_pend) begin
                if (WES !== 1'b1 || RD !== ld_exp.rd || WD !== ld_exp.wd)
                    $display("FAIL fill_ld c%0d: wes=%b rd=%0d wd=%h, need rd=%0d wd=%h", c, WES, RD, WD, ld_exp.rd, ld_exp.wd);
                else n_pass++;
            end else if (WES === 1'b1) begin
                if (alu_q.size() == 0) $display("FAIL fill_extra c%0d: unexpected write rd=%0d wd=%h", c, RD, WD);
                else begin
                    exp = alu_q.pop_front();
                    if (RD !== exp.rd || WD !== exp.wd)
                        $display("FAIL fill_order c%0d: rd=%0d wd=%h, need rd=%0d wd=%h", c, RD, WD, exp.rd, exp.wd);
                    else n_pass++;
                end
            end else n_pass++;
            if (c == 3 || c == 5) begin
                n_chk++;
                if (pending !== 3'd4 || alu_stall !== 1'b1)
                    $display("FAIL fill_full c%0d: pending=%0d stall=%b, need 4/1", c, pending, alu_stall);
                else n_pass++;
            end
        end
        n_chk++;
        if (k != 10 || pending !== 3'd0 || alu_stall !== 1'b0 || alu_q.size() != 0)
            $display("FAIL fill_drain: sent=%0d pending=%0d stall=%b model=%0d, need 10/0/0/0", k, pending, alu_stall, alu_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        bit  lv = 0, av = 0;
        int  lrd = 0, lwd = 0, ard = 0, awd = 0;
        wr_t exp;
        for (int c = 0; c < 320; c++) begin
            if (c < 300) begin
                lv  = ($urandom_range(0, 2) == 0);
                lrd = int'($urandom_range(0, 7));
                lwd = int'($urandom_range(0, 16'hFFFF));
                if (!(av && alu_stall === 1'b1)) begin
                    av  = ($urandom_range(0, 1) == 1);
                    ard = int'($urandom_range(0, 7));
                    awd = int'($urandom_range(0, 16'hFFFF));
                end
            end else begin
                lv = 0;
                av = 0;
            end
            drive(lv, lrd, lwd, av, ard, awd);
            @(posedge clk);
            #1;
            n_chk++;
            if (ld_pend) begin
                if (WES !== 1'b1 || RD !== ld_exp.rd || WD !== ld_exp.wd)
                    $display("FAIL rand_ld c%0d: wes=%b rd=%0d wd=%h, need rd=%0d wd=%h", c, WES, RD, WD, ld_exp.rd, ld_exp.wd);
                else n_pass++;
            end else if (WES === 1'b1) begin
                if (alu_q.size() == 0) $display("FAIL rand_extra c%0d: unexpected write rd=%0d wd=%h", c, RD, WD);
                else begin
                    exp = alu_q.pop_front();
                    if (RD !== exp.rd || WD !== exp.wd)
                        $display("FAIL rand_alu c%0d: rd=%0d wd=%h, need rd=%0d wd=%h", c, RD, WD, exp.rd, exp.wd);
                    else n_pass++;
                end
            end else n_pass++;
            if (pending > 3'd4) begin
                n_chk++;
                $display("FAIL rand_bound c%0d: pending=%0d exceeds 4", c, pending);
            end
        end
        n_chk++;
        if (pending !== 3'd0 || alu_q.size() != 0)
            $display("FAIL rand_drain: pending=%0d model=%0d, need 0/0", pending, alu_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1 + c, 16'h7000 + c, 1, 20 + c, 16'h8000 + c);
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (pending !== 3'd3 || WES !== 1'b1) $display("FAIL mid_prefill: pending=%0d wes=%b, need 3/1", pending, WES);
        else n_pass++;
        #2;
        set_idle();
        rst = 1'b0;
        #1;
        n_chk++;
        if (WES !== 1'b0 || pending !== 3'd0 || alu_stall !== 1'b0)
            $display("FAIL mid_async: wes=%b pending=%0d stall=%b, need 0/0/0", WES, pending, alu_stall);
        else n_pass++;
        alu_q.delete();
        ld_pend = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (WES !== 1'b0 || pending !== 3'd0)
                $display("FAIL mid_stale c%0d: wes=%b rd=%0d pending=%0d, need 0/0", c, WES, RD, pending);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_conflict();
        test_zero_reg();
        test_squash();
        test_fill();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scalar_wb_arbiter.md
SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 Parameter DW, default 16, data width of every write-data path.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DEPTH, default 4, ALU-result buffer entries (power of two, >=2).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 alu_valid  in  1  ALU result present this cycle.
REQ-007 alu_rd  in  AW  ALU destination register.
REQ-008 alu_wd  in  DW  ALU result data.
REQ-009 alu_stall  out  1  buffer full; upstream shall hold ALU result stable.
REQ-010 ld_valid  in  1  load result present; never back-pressured.
REQ-011 ld_rd  in  AW  load destination register.
REQ-012 ld_wd  in  DW  load data.
REQ-013 RD  out  AW  write address to scalar register file.
REQ-014 WD  out  DW  write data to scalar register file.
REQ-015 WES  out  1  write enable to scalar register file.
REQ-016 pending  out  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-017 Exactly one register-file write issued per cycle at most; RD/WD/WES registered, 1-cycle latency from selected source.
REQ-018 Selection priority per cycle: ld_valid, then buffer head (pending>0), then direct ALU input (alu_valid, buffer empty).
REQ-019 ALU result accepted when alu_valid=1 and alu_stall=0; if not issued directly it is pushed to buffer tail same edge.
REQ-020 ALU result never bypasses a non-empty buffer; ALU writes issue in acceptance order.
REQ-021 alu_stall = (pending == DEPTH), derived from registered count only; simultaneous pop does not clear stall that cycle.
REQ-022 Load results are younger than every buffered or same-cycle ALU result: buffer entries with rd == ld_rd are squashed (never issued, still occupy slot until popped without write).
REQ-023 Same-cycle accepted ALU result with alu_rd == ld_rd is accepted and discarded (not pushed, not issued).
REQ-024 Popping a squashed head produces WES=0 that cycle and does not consume a load slot.
REQ-025 Simultaneous push and pop keeps pending unchanged; pointers wrap modulo DEPTH.
REQ-026 No source selected: WES=0; RD and WD hold previous values.
REQ-027 pending never exceeds DEPTH nor underflows.

Reset
REQ-028 While rst=0: WES=0, RD=0, WD=0, pending=0, alu_stall=0, all squash flags cleared, pointers 0.
REQ-029 Reset mid-operation discards all buffered results; no write issued in first cycle after release unless a source is valid.

Configuration
REQ-030 Macro WB_ZERO_DROP_EN defined: any result (load or ALU) with rd==0 is discarded at acceptance; WES never asserted with RD=0.
REQ-031 WB_ZERO_DROP_EN undefined: rd==0 results are handled as any other register.

Verification
REQ-032 ALU only: alu_valid=1, alu_rd=7, alu_wd=16'hAABB -> next cycle RD=7, WD=16'hAABB, WES=1, pending=0.
REQ-033 Conflict: ld (rd=3, 16'h1234) and ALU (rd=5, 16'h5678) same cycle -> cycle+1 load written, cycle+2 rd=5 written, pending 1 then 0.
REQ-034 Fill: ld_valid held 1 for 6 cycles with ALU results every cycle -> alu_stall=1 once pending=4; no ALU result lost or reordered after loads stop.
REQ-035 Squash: buffer holds rd=10 value 16'h0001, then load rd=10 value 16'h0002 -> final register 10 value 16'h0002; buffered write never asserts WES.
REQ-036 Reset: assert rst=0 with pending=3 -> WES=0, pending=0 immediately (asynchronous), no stale write after release.
REQ-037 With WB_ZERO_DROP_EN: ALU rd=0 value 16'hFFFF -> WES stays 0; without macro -> RD=0, WES=1 next cycle.
